operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
Parametrised byte-serial front end for the arithmetic labs. It collects NUM_OPS operands of DATA_W bits, one byte per enter press from the switches, and hands them to a compute unit with a valid/ready handshake. It then latches the unit's result and pages it onto DIGITS seven-segment displays, advancing one page per enter press. It replaces the fixed two-operand, 32-bit, four-display control/datapath pair, and sits directly under the board top.

Parameters:
DATA_W, 32, operand and result width in bits; must be a multiple of 8 and of 4*DIGITS.
NUM_OPS, 2, number of operands collected before a compute request.
DIGITS, 4, number of hex displays driven.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enter  in  1  active-high button level, asynchronous to clk
inputdata  in  8  byte from the switches
op_bus  out  NUM_OPS*DATA_W  operands; operand k occupies bits [k*DATA_W +: DATA_W]
op_valid  out  1  operands ready for the compute unit
op_ready  in  1  compute unit accepts the operands
res_data  in  DATA_W  result from the compute unit
res_valid  in  1  one-cycle result strobe
loading  out  1  high in the LOAD state
page  out  $clog2(PAGES)+1  index of the result page on display
disp  out  DIGITS*7  segments; digit i occupies bits [i*7 +: 7], active-low, bit order {g,f,e,d,c,b,a}

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. There is no asynchronous reset.
- Constants: PAGES = DATA_W/(4*DIGITS); BYTES = DATA_W/8.
- enter path: two-flop synchroniser, then a previous-value flop. press = s2 & ~s3.
- Press timing: if enter is first sampled high at edge E0, the press takes effect at edge E2. inputdata is sampled at E2.
- Holding enter produces exactly one press. A new press requires enter low for at least one sampled cycle.
- States: LOAD, REQ, WAIT, SHOW.
- LOAD:
  - Each press writes inputdata into byte byte_idx of operand op_idx. Bytes go least-significant first.
  - byte_idx and op_idx are counters that increment on each press.
  - A press on the last byte of the last operand moves to REQ on the same edge.
- REQ: op_valid = 1. op_bus is stable. On op_valid & op_ready, move to WAIT.
- WAIT:
  - res_valid latches res_data into the result register, sets page = 0, and moves to SHOW.
  - Presses are ignored.
- SHOW:
  - disp shows hex digits [page*DIGITS*4 +: DIGITS*4] of the result. Digit 0 is the rightmost.
  - Each press increments page, wrapping from PAGES-1 to 0.
- Return from SHOW: a press while inputdata == 8'hFF returns to LOAD and clears the counters. The "0xFF" escape takes priority over paging.
- Display outside SHOW:
  - disp[0] and disp[1] show the low and high nibbles of the last captured byte.
  - Remaining digits are blank (7'h7F).
  - After reset, all digits are blank.
- res_valid outside WAIT is ignored. op_ready outside REQ is ignored.
- Reset values: state = LOAD; all counters = 0; op_bus = 0; result register = 0; op_valid = 0; loading = 1; page = 0; disp all 7'h7F; synchroniser flops = 0.
- Reset mid-operation (any state) discards partial operands and any pending handshake. op_valid drops on the cycle after reset is sampled.
- Outputs: op_valid, loading, page and disp are all registered. disp updates one cycle after the value it reflects changes.
- Parameter checks: DATA_W % (4*DIGITS) != 0, or DATA_W % 8 != 0, is an elaboration-time $error.

Decomposition:
- Package seq_pkg:
  - state enum (LOAD/REQ/WAIT/SHOW);
  - SEG_BLANK = 7'h7F;
  - seven-segment hex lookup constants;
  - ESC_BYTE = 8'hFF.
- Sub-module hex7seg: 4-bit hex to 7-bit active-low segments, combinational. Instantiated DIGITS times with a generate loop.
- The synchroniser and edge detect stay inline.

Test Plan:
1. Reset, load A = 0x3F800000 (bytes 00,00,80,3F) and B = 0x40000000 (bytes 00,00,00,40) -> op_valid rises after the 8th press; op_bus = 64'h40000000_3F800000; loading = 0.
2. Hold op_ready low for 5 cycles, then pulse it -> op_valid stays high and op_bus stays stable until the handshake, then op_valid = 0 and the state is WAIT.
3. Stub returns res_data = 0x40400000 -> page 0: disp = {7'h40,7'h40,7'h40,7'h40} ("0000"); one press gives page 1: disp = {7'h19,7'h40,7'h19,7'h40} ("4040"); one more press wraps to page 0.
4. Hold enter high for 20 cycles during LOAD -> exactly one byte captured; bounce at 1-cycle granularity with low gaps -> one capture per low-to-high transition.
5. Presses during WAIT, then a res_valid pulse while in LOAD -> no state or counter change.
6. In SHOW, press with inputdata = 8'hFF -> LOAD, loading = 1, counters 0. Assert reset mid-load after 3 bytes -> op_bus = 0, disp blank, next byte lands in operand 0 byte 0.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the operand sequencer.
//   seq_state_t : sequencer states (LOAD, REQ, WAIT, SHOW)
//   SEG_BLANK   : all segments off (active-low)
//   HEX_SEG     : hex digit -> active-low segments, bit order {g,f,e,d,c,b,a}
//   ESC_BYTE    : switch value that returns from SHOW to LOAD
package seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SHOW = 2'd3
  } seq_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] ESC_BYTE  = 8'hFF;

  // Index 0 is the first entry.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit to seven-segment decoder.
//   hex : 4-bit value to show
//   seg : active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import seq_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: byte-serial operand loader and paged result display.
// Collects NUM_OPS operands of DATA_W bits one switch byte per enter press
// (least-significant byte first), offers them to a compute unit over a
// valid/ready handshake, latches the returned result and pages it across
// DIGITS hex displays, one page per press. A press with 0xFF on the switches
// while showing the result returns to loading.
//   clk, reset : clock, synchronous active-high reset
//   enter      : raw button level (asynchronous to clk)
//   inputdata  : switch byte
//   op_bus     : operand k at [k*DATA_W +: DATA_W]
//   op_valid   : operands offered; op_ready accepts them
//   res_data   : result, captured on res_valid while waiting
//   loading    : high while loading operands
//   page       : result page currently on the displays
//   disp       : digit i at [i*7 +: 7], active-low
module operand_sequencer
  import seq_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int NUM_OPS = 2,
  parameter  int DIGITS  = 4,
  localparam int PAGES   = DATA_W / (4 * DIGITS),
  localparam int BYTES   = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enter,
  input  logic [7:0]                    inputdata,
  output logic [NUM_OPS*DATA_W-1:0]     op_bus,
  output logic                          op_valid,
  input  logic                          op_ready,
  input  logic [DATA_W-1:0]             res_data,
  input  logic                          res_valid,
  output logic                          loading,
  output logic [$clog2(PAGES)+1-1:0]    page,
  output logic [DIGITS*7-1:0]           disp
);

  localparam int PW  = $clog2(PAGES) + 1;
  localparam int BW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int OW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int DW4 = DIGITS * 4;

  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
  localparam logic [OW-1:0] OP_LAST   = OW'(NUM_OPS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  if ((DATA_W % (4 * DIGITS)) != 0 || (DATA_W % 8) != 0) begin : g_bad_params
    $error("operand_sequencer: DATA_W must be a multiple of 8 and of 4*DIGITS");
  end

  logic       s1_reg, s2_reg, s3_reg;
  logic       press;
  seq_state_t state_reg;
  logic [BW-1:0]       byte_idx_reg;
  logic [OW-1:0]       op_idx_reg;
  logic [7:0]          op_bytes_reg [NUM_OPS][BYTES];
  logic [DATA_W-1:0]   result_reg;
  logic [7:0]          last_byte_reg;
  logic                byte_seen_reg;
  logic                op_valid_reg;
  logic                loading_reg;
  logic [PW-1:0]       page_reg;
  logic [DIGITS*7-1:0] disp_reg;
  logic [DIGITS*7-1:0] disp_next;

  // Rising edge of the synchronised button: one press per low-to-high.
  assign press = s2_reg & ~s3_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg        <= 1'b0;
      s2_reg        <= 1'b0;
      s3_reg        <= 1'b0;
      state_reg     <= ST_LOAD;
      byte_idx_reg  <= '0;
      op_idx_reg    <= '0;
      for (int k = 0; k < NUM_OPS; k++) begin
        for (int b = 0; b < BYTES; b++) begin
          op_bytes_reg[k][b] <= '0;
        end
      end
      result_reg    <= '0;
      last_byte_reg <= '0;
      byte_seen_reg <= 1'b0;
      op_valid_reg  <= 1'b0;
      loading_reg   <= 1'b1;
      page_reg      <= '0;
      disp_reg      <= {DIGITS{SEG_BLANK}};
    end else begin
      s1_reg   <= enter;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      disp_reg <= disp_next;
      case (state_reg)
        ST_LOAD: begin
          if (press) begin
            op_bytes_reg[op_idx_reg][byte_idx_reg] <= inputdata;
            last_byte_reg <= inputdata;
            byte_seen_reg <= 1'b1;
            if (byte_idx_reg == BYTE_LAST) begin
              byte_idx_reg <= '0;
              if (op_idx_reg == OP_LAST) begin
                op_idx_reg   <= '0;
                state_reg    <= ST_REQ;
                op_valid_reg <= 1'b1;
                loading_reg  <= 1'b0;
              end else begin
                op_idx_reg <= op_idx_reg + OW'(1);
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + BW'(1);
            end
          end
        end
        ST_REQ: begin
          if (op_ready) begin
            state_reg    <= ST_WAIT;
            op_valid_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            result_reg <= res_data;
            page_reg   <= '0;
            state_reg  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (press) begin
            // The escape byte wins over paging.
            if (inputdata == ESC_BYTE) begin
              state_reg    <= ST_LOAD;
              loading_reg  <= 1'b1;
              byte_idx_reg <= '0;
              op_idx_reg   <= '0;
            end else if (page_reg == PAGE_LAST) begin
              page_reg <= '0;
            end else begin
              page_reg <= page_reg + PW'(1);
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  // Operand bytes laid out little-endian, operand 0 in the low word.
  genvar gi, gj;
  for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
    for (gj = 0; gj < BYTES; gj++) begin : g_byte
      assign op_bus[(gi*BYTES + gj)*8 +: 8] = op_bytes_reg[gi][gj];
    end
  end

  // Digits of the current result page, digit 0 at the low nibble.
  logic             show;
  logic [DW4-1:0]   page_digits;
  assign show        = (state_reg == ST_SHOW);
  assign page_digits = DW4'(result_reg >> (32'(page_reg) * 32'(DW4)));

  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    logic [6:0] seg;
    hex7seg u_hex7seg (.hex(nib), .seg(seg));
    if (gi < 2) begin : g_byte_digit
      // Outside SHOW the two right digits echo the last captured byte.
      assign nib = show ? page_digits[gi*4 +: 4] : last_byte_reg[gi*4 +: 4];
      assign disp_next[gi*7 +: 7] = (show || byte_seen_reg) ? seg : SEG_BLANK;
    end else begin : g_res_digit
      assign nib = page_digits[gi*4 +: 4];
      assign disp_next[gi*7 +: 7] = show ? seg : SEG_BLANK;
    end
  end

  assign op_valid = op_valid_reg;
  assign loading  = loading_reg;
  assign page     = page_reg;
  assign disp     = disp_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 2;
  localparam int DIGITS  = 4;
  localparam int PAGES   = 2;
  localparam int TOTAL   = 8;   // bytes per full operand set
  localparam int BUS_W   = NUM_OPS * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              enter;
  logic [7:0]        inputdata;
  logic [BUS_W-1:0]  op_bus;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              loading;
  logic [1:0]        page;
  logic [DIGITS*7-1:0] disp;

  always #5 clk = ~clk;

  operand_sequencer #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
    .op_bus(op_bus), .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_valid(res_valid), .loading(loading),
    .page(page), .disp(disp)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0=load 1=request 2=wait 3=show
  int               m_phase;
  int               m_count;     // bytes entered in this load round
  logic [BUS_W-1:0] m_bus;
  logic [7:0]       m_last;
  bit               m_last_ok;
  logic [31:0]      m_res;
  int               m_page;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [DIGITS*7-1:0] exp_disp();
    logic [DIGITS*7-1:0] d;
    d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (m_phase == 3)
        d[i*7 +: 7] = seg_of(4'(m_res >> ((m_page * DIGITS + i) * 4)));
      else if (i == 0 && m_last_ok)
        d[i*7 +: 7] = seg_of(m_last[3:0]);
      else if (i == 1 && m_last_ok)
        d[i*7 +: 7] = seg_of(m_last[7:4]);
      else
        d[i*7 +: 7] = 7'h7F;
    end
    return d;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_count = 0; m_bus = '0; m_last = '0; m_last_ok = 0;
    m_res = '0; m_page = 0;
  endfunction

  function automatic void model_press(input logic [7:0] b);
    if (m_phase == 0) begin
      m_bus[m_count*8 +: 8] = b;
      m_last = b; m_last_ok = 1;
      m_count++;
      if (m_count == TOTAL) begin m_phase = 1; m_count = 0; end
    end else if (m_phase == 3) begin
      if (b == 8'hFF) begin m_phase = 0; m_count = 0; end
      else m_page = (m_page + 1) % PAGES;
    end
  endfunction

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":op_valid"}, BUS_W'(op_valid), BUS_W'(m_phase == 1));
    chk({tag, ":loading"},  BUS_W'(loading),  BUS_W'(m_phase == 0));
    chk({tag, ":page"},     BUS_W'(page),     BUS_W'(m_page));
    chk({tag, ":disp"},     BUS_W'(disp),     BUS_W'(exp_disp()));
    chk({tag, ":op_bus"},   op_bus,           m_bus);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    inputdata = b;
    enter = 1'b1;
    tick(4);
    enter = 1'b0;
    model_press(b);
    tick(3);
    $display("press %02h -> phase %0d count %0d page %0d", b, m_phase, m_count, m_page);
  endtask

  task automatic do_reset();
    enter = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    $display("reset");
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    if (m_phase == 1) m_phase = 2;
    $display("handshake");
  endtask

  task automatic result(input logic [31:0] r);
    res_data = r; res_valid = 1'b1;
    tick(1);
    res_valid = 1'b0;
    tick(1);
    if (m_phase == 2) begin m_phase = 3; m_res = r; m_page = 0; end
    $display("result %08h -> phase %0d", r, m_phase);
  endtask

  logic [7:0] plan_bytes [TOTAL] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};

  initial begin
    logic [7:0] b;
    reset = 1'b1; enter = 1'b0; inputdata = '0; op_ready = 1'b0;
    res_data = '0; res_valid = 1'b0;
    model_reset();
    tick(2);
    reset = 1'b0;

    // Reset state
    check_all("reset");
    chk("reset_blank", BUS_W'(disp), BUS_W'({DIGITS{7'h7F}}));

    // Directed load of A = 0x3F800000, B = 0x40000000
    for (int i = 0; i < TOTAL; i++) begin
      press(plan_bytes[i]);
      if (i == TOTAL - 2) chk("valid_before_last", BUS_W'(op_valid), '0);
    end
    check_all("loaded");
    chk("plan_bus", op_bus, 64'h40000000_3F800000);

    // op_valid and op_bus hold while op_ready is low
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("req_hold_valid", BUS_W'(op_valid), BUS_W'(1));
      chk("req_hold_bus", op_bus, 64'h40000000_3F800000);
    end
    handshake();
    check_all("after_handshake");

    // Presses in WAIT are ignored
    press(8'h55);
    press(8'hFF);
    check_all("wait_presses");

    // Result paging
    result(32'h40400000);
    check_all("show_p0");
    chk("show_p0_const", BUS_W'(disp), BUS_W'({7'h40, 7'h40, 7'h40, 7'h40}));
    press(8'h12);
    check_all("show_p1");
    chk("show_p1_const", BUS_W'(disp), BUS_W'({7'h19, 7'h40, 7'h19, 7'h40}));
    press(8'h34);
    check_all("show_wrap");

    // Escape back to LOAD, then reset mid-load after 3 bytes
    press(8'hFF);
    check_all("escape");
    for (int i = 0; i < 3; i++) press(8'($urandom_range(0, 254)));
    check_all("partial_load");
    do_reset();
    check_all("mid_reset");
    chk("mid_reset_blank", BUS_W'(disp), BUS_W'({DIGITS{7'h7F}}));
    b = 8'($urandom);
    press(b);
    chk("first_byte_after_reset", op_bus, BUS_W'(b));

    // Holding enter yields a single press
    b = 8'($urandom);
    inputdata = b; enter = 1'b1;
    tick(20);
    enter = 1'b0;
    model_press(b);
    tick(3);
    check_all("hold_enter");

    // One-cycle bounce: one capture per low-to-high
    b = 8'($urandom);
    inputdata = b;
    for (int i = 0; i < 3; i++) begin
      enter = 1'b1; tick(1);
      enter = 1'b0; tick(1);
      model_press(b);
    end
    tick(4);
    check_all("bounce");

    // res_valid and op_ready are ignored during LOAD
    res_data = $urandom; res_valid = 1'b1; op_ready = 1'b1;
    tick(1);
    res_valid = 1'b0; op_ready = 1'b0;
    tick(2);
    check_all("stray_strobes");

    // Finish the load, then reset during REQ
    while (m_phase == 0) press(8'($urandom));
    check_all("req_reached");
    do_reset();
    check_all("reset_in_req");

    // Randomised rounds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < TOTAL; i++) press(8'($urandom));
      check_all("rnd_loaded");
      repeat ($urandom_range(0, 4)) begin
        tick(1);
        chk("rnd_req_hold", BUS_W'(op_valid), BUS_W'(1));
      end
      handshake();
      repeat ($urandom_range(0, 2)) press(8'($urandom));
      check_all("rnd_wait");
      result($urandom);
      check_all("rnd_show");
      repeat ($urandom_range(1, 3)) begin
        press(8'($urandom_range(0, 254)));
        check_all("rnd_page");
      end
      press(8'hFF);
      check_all("rnd_escape");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
